// File: rtl/wb_pkg.sv
// Shared types for the writeback stage.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package wb_pkg;

    localparam int WB_W = 8;    // register-file data width
    localparam int WB_A = 4;    // register-file address width

    typedef enum logic {
        WB_IDLE,
        WB_WAIT_MEM
    } wb_state_t;

    // One register-file write: destination and value.
    typedef struct packed {
        logic [WB_A-1:0] waddr;
        logic [WB_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_bypass.sv
// Read-port comparator: forwards the in-flight write and flags a pending-load destination.
// Latency: purely combinational.
// Backpressure: none; outputs are advisory to the read stage.
//
// Ports:
//   RfWriteEn/RfWaddr/RfDataIn : registered write currently presented to the register file
//   Pending/PendReg            : load outstanding and its destination register
//   Raddr                      : register-file read address being checked
//   Byp/BypData                : read hits the in-flight write, forwarded value (0 when no hit)
//   Busy                       : read targets the outstanding load's destination
module wb_bypass
    import wb_pkg::*;
#(
    parameter int W = WB_W,
    parameter int A = WB_A
) (
    input  logic         RfWriteEn,
    input  logic [A-1:0] RfWaddr,
    input  logic [W-1:0] RfDataIn,
    input  logic         Pending,
    input  logic [A-1:0] PendReg,
    input  logic [A-1:0] Raddr,
    output logic         Byp,
    output logic [W-1:0] BypData,
    output logic         Busy
);

    assign Byp     = RfWriteEn && (Raddr == RfWaddr);
    assign BypData = Byp ? RfDataIn : '0;
    assign Busy    = Pending && (Raddr == PendReg);

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: merges ALU results and load returns onto the single register-file write port.
// Latency: ALU result 1 cycle (2 if skidded behind a load return); load data 1 cycle after MemRvalid.
// Backpressure: Stall holds upstream on skid drain, second load, or WAW against the pending load.
//
// Ports:
//   Clk, Reset                    : clock, synchronous active-high reset
//   AluValid/AluWaddr/AluData     : ALU result (held by upstream while Stall=1)
//   LoadReq/LoadWaddr             : load issue (held by upstream while Stall=1)
//   MemRvalid/MemRdata            : load data return pulse
//   RaddrA/RaddrB                 : register-file read addresses for bypass/busy
//   RfWriteEn/RfWaddr/RfDataIn    : registered register-file write port
//   BypA/BypB, BypDataA/BypDataB  : forwarding of the in-flight write
//   BusyA/BusyB                   : read targets the outstanding load
//   Stall, Pending, LoadErr       : upstream hold, load outstanding, sticky spurious-return flag
module wb_stage
    import wb_pkg::*;
#(
    parameter int W = WB_W,
    parameter int A = WB_A
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         AluValid,
    input  logic [A-1:0] AluWaddr,
    input  logic [W-1:0] AluData,
    input  logic         LoadReq,
    input  logic [A-1:0] LoadWaddr,
    input  logic         MemRvalid,
    input  logic [W-1:0] MemRdata,
    input  logic [A-1:0] RaddrA,
    input  logic [A-1:0] RaddrB,
    output logic         RfWriteEn,
    output logic [A-1:0] RfWaddr,
    output logic [W-1:0] RfDataIn,
    output logic         BypA,
    output logic         BypB,
    output logic [W-1:0] BypDataA,
    output logic [W-1:0] BypDataB,
    output logic         BusyA,
    output logic         BusyB,
    output logic         Stall,
    output logic         Pending,
    output logic         LoadErr
);

    wb_state_t    state_q, state_d;
    logic [A-1:0] pend_reg;
    wb_entry_t    skid_q;
    logic         skid_vld;
    wb_entry_t    rf_q;
    logic         rf_we;
    logic         load_err;

    logic wait_mem;
    logic alu_acc;
    logic load_acc;
    logic mem_ret;

    assign wait_mem = (state_q == WB_WAIT_MEM);

    // MemRvalid is deliberately absent: a return frees the port only from the next cycle on.
    assign Stall = skid_vld
                 | (wait_mem && LoadReq)
                 | (wait_mem && AluValid && (AluWaddr == pend_reg));

    assign alu_acc  = AluValid && !Stall;
    // The ALU wins if upstream ever drives both; the load is simply not taken.
    assign load_acc = LoadReq && !Stall && !AluValid;
    assign mem_ret  = wait_mem && MemRvalid;

    always_comb begin
        state_d = state_q;
        case (state_q)
            WB_IDLE:     if (load_acc)  state_d = WB_WAIT_MEM;
            WB_WAIT_MEM: if (MemRvalid) state_d = WB_IDLE;
            default:                    state_d = WB_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q  <= WB_IDLE;
            pend_reg <= '0;
            skid_vld <= 1'b0;
            skid_q   <= '0;
            rf_we    <= 1'b0;
            rf_q     <= '0;
            load_err <= 1'b0;
        end else begin
            state_q <= state_d;

            if (load_acc)
                pend_reg <= LoadWaddr;

            if (!wait_mem && MemRvalid)
                load_err <= 1'b1;

            // Write-port arbitration: load return, then skid drain, then ALU.
            if (mem_ret) begin
                rf_we      <= 1'b1;
                rf_q.waddr <= pend_reg;
                rf_q.data  <= MemRdata;
                if (alu_acc) begin
                    skid_q.waddr <= AluWaddr;
                    skid_q.data  <= AluData;
                    skid_vld     <= 1'b1;
                end
            end else if (skid_vld) begin
                rf_we    <= 1'b1;
                rf_q     <= skid_q;
                skid_vld <= 1'b0;
            end else if (alu_acc) begin
                rf_we      <= 1'b1;
                rf_q.waddr <= AluWaddr;
                rf_q.data  <= AluData;
            end else begin
                rf_we <= 1'b0;
            end
        end
    end

    assign RfWriteEn = rf_we;
    assign RfWaddr   = rf_q.waddr;
    assign RfDataIn  = rf_q.data;
    assign Pending   = wait_mem;
    assign LoadErr   = load_err;

    wb_bypass #(.W(W), .A(A)) u_byp_a (
        .RfWriteEn (rf_we),
        .RfWaddr   (rf_q.waddr),
        .RfDataIn  (rf_q.data),
        .Pending   (wait_mem),
        .PendReg   (pend_reg),
        .Raddr     (RaddrA),
        .Byp       (BypA),
        .BypData   (BypDataA),
        .Busy      (BusyA)
    );

    wb_bypass #(.W(W), .A(A)) u_byp_b (
        .RfWriteEn (rf_we),
        .RfWaddr   (rf_q.waddr),
        .RfDataIn  (rf_q.data),
        .Pending   (wait_mem),
        .PendReg   (pend_reg),
        .Raddr     (RaddrB),
        .Byp       (BypB),
        .BypData   (BypDataB),
        .Busy      (BusyB)
    );

endmodule
